// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings shared by the universal shift register and its bit cells
package univ_shift_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one register bit, a 4:1 mode mux feeding an async-reset flop
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears q
//   mode     hold / shift right / shift left / load
//   upper    next-more-significant source, taken on shift right
//   lower    next-less-significant source, taken on shift left
//   load_bit parallel data bit, taken on load
//   q        stored bit
module usr_bit_cell
    import univ_shift_reg_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  mode_t mode,
    input  logic  upper,
    input  logic  lower,
    input  logic  load_bit,
    output logic  q
);

    logic d;

    // Any unknown or hold encoding falls to the default, keeping the bit.
    always_comb begin
        d = q;
        case (mode)
            MODE_SHR:  d = upper;
            MODE_SHL:  d = lower;
            MODE_LOAD: d = load_bit;
            default:   d = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register (hold, shift right, shift left, parallel load)
//   CLK      rising-edge clock
//   RST_N    asynchronous active-low reset, clears OUT
//   INP      parallel load data
//   select   00 hold, 01 shift right, 10 shift left, 11 load
//   leftInp  serial bit entering the MSB on shift right
//   rightInp serial bit entering the LSB on shift left
//   rotate   wrap the discarded bit back in instead of the serial input
//            (only when UNIV_SHIFT_REG_ROTATE_EN is defined)
//   OUT      register contents, straight from the flops
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] INP,
    input  logic [1:0]       select,
    input  logic             leftInp,
    input  logic             rightInp,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] OUT
);

    logic             msb_fill;
    logic             lsb_fill;
    logic [WIDTH+1:0] ext;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign msb_fill = rotate ? OUT[0] : leftInp;
    assign lsb_fill = rotate ? OUT[WIDTH-1] : rightInp;
`else
    assign msb_fill = leftInp;
    assign lsb_fill = rightInp;
`endif

    // Register padded with its fill bits: bit i sees ext[i+2] above and ext[i] below.
    assign ext = {msb_fill, OUT, lsb_fill};

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        usr_bit_cell u_cell (
            .clk      (CLK),
            .rst_n    (RST_N),
            .mode     (select),
            .upper    (ext[g+2]),
            .lower    (ext[g]),
            .load_bit (INP[g]),
            .q        (OUT[g])
        );
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] INP = '0;
    logic [1:0] select = '0;
    logic       leftInp = 1'b0;
    logic       rightInp = 1'b0;
    logic       rotate = 1'b0;
    logic [3:0] OUT;

    int total = 0;
    int bad = 0;

    univ_shift_reg #(.WIDTH(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .INP      (INP),
        .select   (select),
        .leftInp  (leftInp),
        .rightInp (rightInp),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rotate   (rotate),
`endif
        .OUT      (OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        select = 2'b11;
        INP = v;
        tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        INP = 4'b1001;
        select = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (OUT !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %b want 0000", i, OUT);
            end
        end
        RST_N = 1'b1;
        tick();
        total++;
        if (OUT !== 4'b1001) begin
            bad++;
            $display("FAIL reset_release_load: got %b want 1001", OUT);
        end
    endtask

    task automatic test_load_hold();
        load(4'b1001);
        total++;
        if (OUT !== 4'b1001) begin
            bad++;
            $display("FAIL load: got %b want 1001", OUT);
        end
        select = 2'b00;
        INP = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (OUT !== 4'b1001) begin
                bad++;
                $display("FAIL hold[%0d]: got %b want 1001", i, OUT);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] exp [3] = '{4'b1100, 4'b1110, 4'b0111};
        logic       fill [3] = '{1'b1, 1'b1, 1'b0};
        load(4'b1001);
        select = 2'b01;
        for (int i = 0; i < 3; i++) begin
            leftInp = fill[i];
            tick();
            total++;
            if (OUT !== exp[i]) begin
                bad++;
                $display("FAIL shr[%0d]: got %b want %b", i, OUT, exp[i]);
            end
        end
        leftInp = 1'b0;
    endtask

    task automatic test_shift_left();
        logic [3:0] exp [3] = '{4'b0010, 4'b0100, 4'b1001};
        logic       fill [3] = '{1'b0, 1'b0, 1'b1};
        load(4'b1001);
        select = 2'b10;
        for (int i = 0; i < 3; i++) begin
            rightInp = fill[i];
            tick();
            total++;
            if (OUT !== exp[i]) begin
                bad++;
                $display("FAIL shl[%0d]: got %b want %b", i, OUT, exp[i]);
            end
        end
        rightInp = 1'b0;
    endtask

    task automatic test_x_select();
        load(4'b1011);
        select = 2'bxx;
        INP = 4'b0000;
        leftInp = 1'b0;
        rightInp = 1'b0;
        tick();
        total++;
        if (OUT !== 4'b1011) begin
            bad++;
            $display("FAIL x_select_hold: got %b want 1011", OUT);
        end
    endtask

    task automatic test_async_reset();
        load(4'b1001);
        select = 2'b01;
        leftInp = 1'b1;
        tick();
        total++;
        if (OUT !== 4'b1100) begin
            bad++;
            $display("FAIL async_pre_shift: got %b want 1100", OUT);
        end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (OUT !== 4'b0000) begin
            bad++;
            $display("FAIL async_immediate: got %b want 0000", OUT);
        end
        tick();
        total++;
        if (OUT !== 4'b0000) begin
            bad++;
            $display("FAIL async_held: got %b want 0000", OUT);
        end
        RST_N = 1'b1;
        leftInp = 1'b0;
        load(4'b0101);
        total++;
        if (OUT !== 4'b0101) begin
            bad++;
            $display("FAIL async_resume_load: got %b want 0101", OUT);
        end
    endtask

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    task automatic test_rotate();
        load(4'b1001);
        rotate = 1'b1;
        select = 2'b01;
        leftInp = 1'b0;
        tick();
        total++;
        if (OUT !== 4'b1100) begin
            bad++;
            $display("FAIL rot_right: got %b want 1100", OUT);
        end
        select = 2'b10;
        rightInp = 1'b0;
        tick();
        total++;
        if (OUT !== 4'b1001) begin
            bad++;
            $display("FAIL rot_left: got %b want 1001", OUT);
        end
        select = 2'b11;
        INP = 4'b0110;
        tick();
        total++;
        if (OUT !== 4'b0110) begin
            bad++;
            $display("FAIL rot_load: got %b want 0110", OUT);
        end
        rotate = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_hold();
        test_shift_right();
        test_shift_left();
        test_x_select();
        test_async_reset();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        test_rotate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Universal shift register, default 4 bits, clocked on the rising edge.
- Per cycle it can hold, shift right with serial fill, shift left with serial fill, or parallel load.
- A general-purpose datapath/storage primitive; the output is the register contents directly, with no combinational path from inputs to output.

Parameters:
- WIDTH, 4, register width in bits (≥2).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- INP  input  WIDTH  parallel load data.
- select  input  2  mode select; encoding below.
- leftInp  input  1  serial input entering at the MSB end during shift right.
- rightInp  input  1  serial input entering at the LSB end during shift left.
- OUT  output  WIDTH  register contents, driven directly from flops.
- rotate  input  1  present only with UNIV_SHIFT_REG_ROTATE_EN; see Optional Feature.

Behaviour:
- Reset:
  - RST_N low forces OUT to all zeros immediately, independent of CLK.
  - While RST_N is low, OUT holds zero and ignores all other inputs.
  - The first active edge is the first rising CLK edge with RST_N high.
- All mode actions take effect on the rising CLK edge. Latency is 1 cycle: the new value is visible on OUT after the edge.
- select = 2'b00, hold: OUT unchanged.
- select = 2'b01, shift right (towards LSB):
  - OUT[WIDTH-1] <= leftInp.
  - OUT[i] <= OUT[i+1] for i = WIDTH-2..0.
  - Old OUT[0] is discarded.
- select = 2'b10, shift left (towards MSB):
  - OUT[0] <= rightInp.
  - OUT[i] <= OUT[i-1] for i = 1..WIDTH-1.
  - Old OUT[WIDTH-1] is discarded.
- select = 2'b11, parallel load: OUT <= INP.
- select, INP, leftInp and rightInp are sampled only at the edge; changes between edges have no effect.
- X or Z on select: the register holds its value (default branch = hold).
- Reset asserted mid-shift: OUT goes to zero at once. On release, operation resumes from zero with the mode present at the next edge.
- No enable, no status flags, no wrap-around unless the optional feature is compiled in.

Optional Feature:
- Macro: UNIV_SHIFT_REG_ROTATE_EN.
- When defined:
  - Input port rotate (1 bit) is added.
  - With rotate=1 in mode 01, OUT[WIDTH-1] <= old OUT[0]; leftInp is ignored.
  - With rotate=1 in mode 10, OUT[0] <= old OUT[WIDTH-1]; rightInp is ignored.
  - rotate has no effect in modes 00 and 11.
- When undefined:
  - The port is absent.
  - Shifts always use the serial inputs.

Decomposition:
- Package univ_shift_reg_pkg holds the mode constants: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
- One natural sub-module, usr_bit_cell:
  - Per-bit 4:1 mux (hold / right neighbour / left neighbour / parallel bit) feeding one async-reset flop.
  - Instantiated WIDTH times with a generate loop.
  - Boundary cells receive leftInp/rightInp (or the rotate wrap source).

Test Plan:
- Reset: RST_N=0 with INP=4'b1001, select=11, CLK toggling -> OUT=0000 throughout. Release, one edge -> OUT=1001.
- Load then hold: select=11, INP=1001, one edge -> OUT=1001. Then select=00, INP=0110, 3 edges -> OUT stays 1001.
- Shift right: from OUT=1001, select=01, leftInp=1 -> edge 1: OUT=1100, edge 2: 1110. With leftInp=0 -> edge 3: 0111.
- Shift left: from OUT=1001, select=10, rightInp=0 -> edge 1: OUT=0010, edge 2: 0100. With rightInp=1 -> edge 3: 1001.
- Async reset mid-operation: OUT=1001, shifting right; pulse RST_N low between edges -> OUT=0000 immediately, before the next edge. After release, select=11, INP=0101 -> OUT=0101.
- With UNIV_SHIFT_REG_ROTATE_EN: OUT=1001, rotate=1, select=01, leftInp=0 -> OUT=1100. Then select=10, rightInp=0 -> OUT=1001.
